// File: rtl/uc_pkg.sv
// uc_pkg: shared opcode constants, sequencer state enum and default widths
// for the uc_seq control unit and its return-address stack.
package uc_pkg;

    // Default width of the ALU operation field driven to the datapath.
    localparam int ALUOP_W_DEFAULT = 3;

    // Opcode map. ALU instructions are the whole 000aaa group.
    localparam logic [2:0] OP_ALU_GROUP = 3'b000;
    localparam logic [5:0] OP_LDI       = 6'b001000;
    localparam logic [5:0] OP_JMP       = 6'b010000;
    localparam logic [5:0] OP_JZ        = 6'b010001;
    localparam logic [5:0] OP_JNZ       = 6'b010010;
    localparam logic [5:0] OP_CALL      = 6'b010100;
    localparam logic [5:0] OP_RET       = 6'b010101;
    localparam logic [5:0] OP_HALT      = 6'b111111;

    // Sequencer states; HALT and FAULT are only left through reset.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } seq_state_t;

endpackage

// File: rtl/uc_seq_ret_stack.sv
// ret_stack: parametrised return-address LIFO with occupancy tracking.
// UC_SEQ_STACK_CHECK_EN defined: pushes when full and pops when empty are
// ignored (the owner faults instead). Undefined: the pointer is circular,
// an overflowing push overwrites the oldest entry and occupancy saturates,
// an underflowing pop still steps the pointer back and occupancy stays 0.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign ptr_inc  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign ptr_dec  = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign pop_data = mem[ptr_dec];

`ifdef UC_SEQ_STACK_CHECK_EN
    assign do_push = push & ~full;
    assign do_pop  = pop & ~push & ~empty;
`else
    assign do_push = push;
    assign do_pop  = pop & ~push;
`endif

    // Pointer always names the next free slot; occupancy saturates at both ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr_inc;
            if (!full) count <= count + 1'b1;
        end else if (do_pop) begin
            ptr <= ptr_dec;
            if (!empty) count <= count - 1'b1;
        end
    end

    // Entry storage is not reset; a slot is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/uc_seq.sv
// uc_seq: control unit with program counter, jumps, CALL/RET through a
// hardware return stack, HALT state and optional stack-fault state.
// Optional feature macro: UC_SEQ_STACK_CHECK_EN (stack over/underflow
// detection, sticky stack_err and FAULT state). Reset is async active-low.
module uc_seq
    import uc_pkg::*;
#(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int ALUOP_W     = ALUOP_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [PC_W-1:0]    target,
    input  logic               zero,
    output logic [PC_W-1:0]    pc,
    output logic               s_inc,
    output logic               s_inm,
    output logic               we,
    output logic               wez,
    output logic [ALUOP_W-1:0] AluOP,
    output logic               halted,
    output logic               stack_err
);

`ifdef UC_SEQ_STACK_CHECK_EN
    localparam bit STACK_CHECK = 1'b1;
`else
    localparam bit STACK_CHECK = 1'b0;
`endif

    seq_state_t      state;
    logic            err_q;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] redirect_pc;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pop_data;
    logic            push_req;
    logic            pop_req;
    logic            halt_req;
    logic            stack_full;
    logic            stack_empty;
    logic            stack_fault;

    // Natural PC_W-bit wrap gives max -> 0 for both fetch and return address.
    assign pc_inc      = pc + 1'b1;
    assign stack_fault = STACK_CHECK & ((push_req & stack_full) | (pop_req & stack_empty));
    assign next_pc     = s_inc ? pc_inc : redirect_pc;
    assign halted      = (state != ST_RUN);
    assign stack_err   = err_q;

    // Opcode decode into datapath controls and sequencing requests; all quiet outside RUN.
    always_comb begin
        s_inc       = 1'b0;
        s_inm       = 1'b0;
        we          = 1'b0;
        wez         = 1'b0;
        AluOP       = '0;
        push_req    = 1'b0;
        pop_req     = 1'b0;
        halt_req    = 1'b0;
        redirect_pc = pc;
        if (state == ST_RUN) begin
            s_inc = 1'b1;
            if (Opcode[5:3] == OP_ALU_GROUP) begin
                AluOP = ALUOP_W'(Opcode[2:0]);
                we    = 1'b1;
                wez   = 1'b1;
            end else begin
                case (Opcode)
                    OP_LDI: begin
                        s_inm = 1'b1;
                        we    = 1'b1;
                    end
                    OP_JMP: begin
                        s_inc       = 1'b0;
                        redirect_pc = target;
                    end
                    OP_JZ: begin
                        s_inc       = ~zero;
                        redirect_pc = target;
                    end
                    OP_JNZ: begin
                        s_inc       = zero;
                        redirect_pc = target;
                    end
                    OP_CALL: begin
                        s_inc       = 1'b0;
                        push_req    = 1'b1;
                        redirect_pc = target;
                    end
                    OP_RET: begin
                        s_inc       = 1'b0;
                        pop_req     = 1'b1;
                        redirect_pc = pop_data;
                    end
                    OP_HALT: begin
                        s_inc    = 1'b0;
                        halt_req = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sequencer FSM: advances pc in RUN, parks in HALT/FAULT until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            pc    <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state <= ST_HALT;
                    end else if (stack_fault) begin
                        state <= ST_FAULT;
                        err_q <= 1'b1;
                    end else begin
                        pc <= next_pc;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FAULT;
            endcase
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req & ~stack_fault),
        .pop       (pop_req & ~stack_fault),
        .push_data (pc_inc),
        .pop_data  (pop_data),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule
